key_event_encoder: RTL and testbench

- Consumer end of the keyboard input path: accepts the 17 already-synchronized key levels and converts them into a stream of discrete note events.
- Debounces each key, detects press and release transitions, and serializes them into a small FIFO.
- Downstream note logic drains the FIFO through a valid/ready handshake.
- Sits between the key synchronizer and the voice/oscillator allocation logic.

---
 rtl/key_event_encoder.sv | 133 +++++++++++++
 tb/tb_key_event_encoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Debounces synchronized key levels and queues press/release note events in a small FIFO.
// Optional macro KEY_EVT_RELEASE_EN: when defined, release events are queued too.
module key_event_encoder #(
  parameter int unsigned NKEYS      = 17,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned KW        = $clog2(NKEYS),
  localparam int unsigned PW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NKEYS-1:0] sync_keys,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [KW-1:0]    evt_key,
  output logic             evt_press,
  output logic [NKEYS-1:0] held_keys,
  output logic [PW:0]      fifo_count
);

  logic [NKEYS-1:0] r_held;
  logic [NKEYS-1:0] r_pend;
  logic [7:0]       r_cnt [NKEYS];
  logic [KW:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  logic [7:0]       w_cnt_d [NKEYS];
  logic [NKEYS-1:0] w_toggle;
  logic [NKEYS-1:0] w_grant_vec;
  logic [NKEYS-1:0] w_pend_d;
  logic [KW-1:0]    w_sel;
  logic             w_any;
  logic             w_sel_held;
  logic             w_drop;
  logic             w_full;
  logic             w_pop;
  logic             w_grant;
  logic             w_push;
  logic [KW:0]      w_head;

  // Counter reaching DB_CYCLES toggles the debounced level instead of storing the value.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < NKEYS; i++) begin
      w_cnt_d[i] = '0;
      if (sync_keys[i] != r_held[i]) begin
        if (r_cnt[i] == 8'(DB_CYCLES - 1)) begin
          w_toggle[i] = 1'b1;
        end else begin
          w_cnt_d[i] = r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any = 1'b1;
        w_sel = KW'(i);
      end
    end
  end

  assign w_sel_held = r_held[w_sel];

`ifdef KEY_EVT_RELEASE_EN
  assign w_drop = 1'b0;
`else
  // Releases are retired from the pending set without consuming a FIFO slot.
  assign w_drop = ~w_sel_held;
`endif

  assign w_full      = (r_count == (PW + 1)'(FIFO_DEPTH));
  assign w_pop       = evt_valid & evt_ready;
  assign w_grant     = w_any & (w_drop | ~w_full | w_pop);
  assign w_push      = w_grant & ~w_drop;
  assign w_grant_vec = w_grant ? (NKEYS'(1) << w_sel) : '0;
  // A toggle on the same edge as service re-arms pending for the opposite transition.
  assign w_pend_d    = (r_pend & ~w_grant_vec) ^ w_toggle;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_held <= '0;
      r_pend <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_held <= r_held ^ w_toggle;
      r_pend <= w_pend_d;
      for (int i = 0; i < NKEYS; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_sel, w_sel_held};
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign evt_valid  = (r_count != '0);
  assign evt_key    = evt_valid ? w_head[KW:1] : '0;
  assign evt_press  = evt_valid & w_head[0];
  assign held_keys  = r_held;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder: vector table, directed sequences and a
// randomized run against an event-level reference model.
module tb_key_event_encoder;

  localparam int NK = 17;
  localparam int DB = 4;
  localparam int FD = 4;
`ifdef KEY_EVT_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic          clk;
  logic          nrst;
  logic [NK-1:0] sync_keys;
  logic          evt_ready;
  logic          evt_valid;
  logic [4:0]    evt_key;
  logic          evt_press;
  logic [NK-1:0] held_keys;
  logic [2:0]    fifo_count;

  key_event_encoder #(
    .NKEYS      (NK),
    .DB_CYCLES  (DB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .sync_keys  (sync_keys),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_key    (evt_key),
    .evt_press  (evt_press),
    .held_keys  (held_keys),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: debounced level, stable-run length, pending set, event queue.
  typedef struct {
    int key;
    bit press;
  } ev_t;

  bit [NK-1:0] m_held;
  bit [NK-1:0] m_pend;
  int          m_run [NK];
  ev_t         m_q [$];

  typedef struct {
    logic [NK-1:0] sync;
    logic          ready;
    logic          valid;
    logic [4:0]    key;
    logic          press;
    logic [NK-1:0] held;
    logic [2:0]    count;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_held = '0;
    m_pend = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit          pop;
    bit          do_push;
    int          sel;
    ev_t         e;
    bit [NK-1:0] served;
    bit [NK-1:0] flip;
    pop     = (m_q.size() > 0) && evt_ready;
    do_push = 1'b0;
    served  = '0;
    flip    = '0;
    sel     = -1;
    for (int i = 0; i < NK; i++) begin
      if (m_pend[i] && sel < 0) sel = i;
    end
    if (sel >= 0) begin
      if (!REL && !m_held[sel]) begin
        served[sel] = 1'b1;
      end else if (m_q.size() < FD || pop) begin
        served[sel] = 1'b1;
        do_push     = 1'b1;
        e.key       = sel;
        e.press     = m_held[sel];
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (sync_keys[i] == m_held[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] + 1 == DB) begin
        m_run[i] = 0;
        flip[i]  = 1'b1;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
    end
    m_pend = (m_pend & ~served) ^ flip;
    m_held = m_held ^ flip;
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(e);
  endtask

  task automatic compare();
    bit v;
    v = (m_q.size() > 0);
    chk("valid", evt_valid, v);
    chk("key", evt_key, v ? m_q[0].key : 0);
    chk("press", evt_press, v ? m_q[0].press : 1'b0);
    chk("held", held_keys, m_held);
    chk("count", fifo_count, m_q.size());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cleanup();
    sync_keys = '0;
    evt_ready = 1'b1;
    idle(16);
  endtask

  task automatic drain(input int budget, output int got [$]);
    got.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (evt_valid) got.push_back(int'(evt_key));
      tick();
    end
  endtask

  initial begin
    int got [$];
    int exp5 [6];
    logic [NK-1:0] mask;

    exp5 = '{1, 4, 7, 10, 13, 15};

    vt[0]  = '{17'h20, 1'b1, 1'b0, 5'd0, 1'b0, 17'h0,  3'd0};
    vt[1]  = '{17'h20, 1'b1, 1'b0, 5'd0, 1'b0, 17'h0,  3'd0};
    vt[2]  = '{17'h20, 1'b1, 1'b0, 5'd0, 1'b0, 17'h0,  3'd0};
    vt[3]  = '{17'h20, 1'b1, 1'b0, 5'd0, 1'b0, 17'h20, 3'd0};
    vt[4]  = '{17'h20, 1'b1, 1'b1, 5'd5, 1'b1, 17'h20, 3'd1};
    vt[5]  = '{17'h20, 1'b1, 1'b0, 5'd0, 1'b0, 17'h20, 3'd0};
    vt[6]  = '{17'h0,  1'b1, 1'b0, 5'd0, 1'b0, 17'h20, 3'd0};
    vt[7]  = '{17'h0,  1'b1, 1'b0, 5'd0, 1'b0, 17'h20, 3'd0};
    vt[8]  = '{17'h0,  1'b1, 1'b0, 5'd0, 1'b0, 17'h20, 3'd0};
    vt[9]  = '{17'h0,  1'b1, 1'b0, 5'd0, 1'b0, 17'h0,  3'd0};
    vt[10] = '{17'h0,  1'b1, REL,  REL ? 5'd5 : 5'd0, 1'b0, 17'h0, {2'b00, REL}};
    vt[11] = '{17'h0,  1'b1, 1'b0, 5'd0, 1'b0, 17'h0,  3'd0};

    sync_keys = '0;
    evt_ready = 1'b0;
    nrst      = 1'b1;
    model_reset();
    #1 nrst = 1'b0;
    #2;
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_held", held_keys, '0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_key", evt_key, 5'd0);
    chk("rst_press", evt_press, 1'b0);
    #9 nrst = 1'b1;

    // Idle with keys released.
    idle(10);
    chk("idle_valid", evt_valid, 1'b0);
    chk("idle_count", fifo_count, 3'd0);

    // Single press/release latency table.
    for (int r = 0; r < 12; r++) begin
      sync_keys = vt[r].sync;
      evt_ready = vt[r].ready;
      tick();
      chk($sformatf("vec%0d_valid", r), evt_valid, vt[r].valid);
      chk($sformatf("vec%0d_key", r), evt_key, vt[r].key);
      chk($sformatf("vec%0d_press", r), evt_press, vt[r].press);
      chk($sformatf("vec%0d_held", r), held_keys, vt[r].held);
      chk($sformatf("vec%0d_count", r), fifo_count, vt[r].count);
    end

    // Glitch shorter than the debounce window.
    sync_keys = 17'h8;
    idle(3);
    sync_keys = '0;
    idle(6);
    chk("glitch_held", held_keys, '0);
    chk("glitch_valid", evt_valid, 1'b0);

    // Simultaneous presses queue in index order.
    sync_keys = 17'h10005;
    evt_ready = 1'b0;
    idle(7);
    chk("multi_count", fifo_count, 3'd3);
    evt_ready = 1'b1;
    chk("multi_k0", evt_key, 5'd0);
    tick();
    chk("multi_k2", evt_key, 5'd2);
    tick();
    chk("multi_k16", evt_key, 5'd16);
    tick();
    chk("multi_empty", fifo_count, 3'd0);
    cleanup();

    // Six presses against a four-entry FIFO.
    mask = '0;
    foreach (exp5[i]) mask[exp5[i]] = 1'b1;
    sync_keys = mask;
    evt_ready = 1'b0;
    idle(12);
    chk("full_count", fifo_count, 3'd4);
    chk("full_held", held_keys, mask);
    drain(20, got);
    chk("full_ndelivered", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("full_order%0d", i), (i < got.size()) ? got[i] : -1, exp5[i]);
    end
    cleanup();

    // Key 9 pressed and released while stuck behind lower keys.
    sync_keys = 17'h21F;
    evt_ready = 1'b0;
    idle(8);
    sync_keys = 17'h01F;
    idle(6);
    chk("cancel_held9", held_keys[9], 1'b0);
    chk("cancel_count", fifo_count, 3'd4);
    drain(20, got);
    chk("cancel_n", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cancel_order%0d", i), (i < got.size()) ? got[i] : -1, i);
    end
    cleanup();

    // Asynchronous reset with events queued.
    sync_keys = 17'h0C0;
    evt_ready = 1'b0;
    idle(7);
    chk("pre_rst_count", fifo_count, 3'd2);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_held", held_keys, '0);
    chk("mid_rst_key", evt_key, 5'd0);
    model_reset();
    @(posedge clk);
    #1 nrst = 1'b1;
    sync_keys = '0;
    idle(4);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 9) == 0) sync_keys[i] = ~sync_keys[i];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cleanup();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
